// File: rtl/ex_mdu_seq.sv
// Multi-cycle RV32M multiply/divide sequencer for the EX stage.
// Multiply is radix-2 shift-add, divide is restoring. Both iterate on magnitudes
// and apply the sign in a single fix-up cycle. Divide-by-zero and signed overflow
// are resolved at accept time and go straight to DONE.
//
// Ports:
//   clk_i, rst_i    clock (rising edge), asynchronous active-high reset
//   start_i         issue request, sampled in IDLE or DONE
//   op_i            funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   a_i, b_i        rs1 / rs2 operands, only sampled on the accept edge
//   flush_i         abort to IDLE, no done pulse, result kept
//   busy_o          high in CALC and FIX
//   stall_o         pipeline stall request (combinational)
//   done_o          one-cycle pulse, result_o valid
//   result_o        registered result, held until the next done
module ex_mdu_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned PW   = 2 * XLEN;
  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] divisor_q, divisor_d;  // multiplicand for MUL*, divisor for DIV*
  logic [PW-1:0]   prod_q, prod_d;        // {hi, lo}: product, or {remainder, quotient}
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  // Accept-time operand decode
  logic            is_div, is_rem, a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf, special, acc_neg;
  logic [XLEN-1:0] special_res;

  always_comb begin
    is_div   = op_i[2];
    is_rem   = op_i[2] & op_i[1];
    // DIV/REM signed both; MUL/MULH signed both; MULHSU signed a only.
    a_signed = op_i[2] ? ~op_i[0] : (op_i != 3'd3);
    b_signed = op_i[2] ? ~op_i[0] : ~op_i[1];
    sa       = a_signed & a_i[XLEN-1];
    sb       = b_signed & b_i[XLEN-1];
    mag_a    = sa ? (~a_i + XLEN'(1)) : a_i;
    mag_b    = sb ? (~b_i + XLEN'(1)) : b_i;
    acc_neg  = is_rem ? sa : (sa ^ sb);
    div_zero = (b_i == '0);
    div_ovf  = ~op_i[0] & (a_i == {1'b1, {(XLEN - 1){1'b0}}}) & (b_i == '1);
    special  = is_div & (div_zero | div_ovf);
    if (div_zero) begin
      special_res = is_rem ? a_i : '1;
    end else begin
      special_res = is_rem ? '0 : a_i;
    end
  end

  // One iteration of each algorithm
  logic [XLEN:0]   mul_add;
  logic [PW-1:0]   mul_step;
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] div_diff;
  logic [PW-1:0]   div_step;

  always_comb begin
    mul_add  = {1'b0, prod_q[PW-1:XLEN]} +
               {1'b0, (prod_q[0] ? divisor_q : {XLEN{1'b0}})};
    mul_step = {mul_add, prod_q[XLEN-1:1]};
    rem_sh   = prod_q[PW-1:XLEN-1];
    div_diff = {1'b0, rem_sh} - {2'b00, divisor_q};
    if (!div_diff[XLEN+1]) begin
      div_step = {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    end else begin
      div_step = {rem_sh[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
    end
  end

  // Sign fix-up and result select
  logic [PW-1:0]   prod_s;
  logic [XLEN-1:0] quo, rem, fix_res;

  always_comb begin
    prod_s = neg_q ? (~prod_q + PW'(1)) : prod_q;
    quo    = prod_q[XLEN-1:0];
    rem    = prod_q[PW-1:XLEN];
    case (op_q)
      3'd0:                 fix_res = prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3:     fix_res = prod_s[PW-1:XLEN];
      3'd4, 3'd5:           fix_res = neg_q ? (~quo + XLEN'(1)) : quo;
      default:              fix_res = neg_q ? (~rem + XLEN'(1)) : rem;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_d     = neg_q;
    divisor_d = divisor_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    if (flush_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          state_d = StIdle;
          if (start_i) begin
            op_d      = op_i;
            neg_d     = acc_neg;
            divisor_d = mag_b;
            prod_d    = {{XLEN{1'b0}}, mag_a};
            cnt_d     = '0;
            if (special) begin
              result_d = special_res;
              state_d  = StDone;
            end else begin
              state_d  = StCalc;
            end
          end
        end
        StCalc: begin
          prod_d = op_q[2] ? div_step : mul_step;
          cnt_d  = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            state_d = StFix;
          end
        end
        StFix: begin
          result_d = fix_res;
          state_d  = StDone;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      op_q      <= '0;
      neg_q     <= 1'b0;
      divisor_q <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      divisor_q <= divisor_d;
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  assign busy_o   = (state_q == StCalc) || (state_q == StFix);
  assign done_o   = (state_q == StDone);
  assign stall_o  = (start_i & ((state_q == StIdle) || (state_q == StDone))) | busy_o;
  assign result_o = result_q;

endmodule

// File: tb/tb_ex_mdu_seq.sv
module tb_ex_mdu_seq;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, stall, done;
  logic [31:0] result;

  ex_mdu_seq #(.XLEN(32)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .op_i    (op),
    .a_i     (a),
    .b_i     (b),
    .flush_i (flush),
    .busy_o  (busy),
    .stall_o (stall),
    .done_o  (done),
    .result_o(result)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model from the RV32M definitions using wide integer arithmetic.
  function automatic logic [31:0] ref_mdu(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
    longint      xs, ys, xu, yu, p;
    logic [63:0] pv;
    xs = longint'($signed(x));
    ys = longint'($signed(y));
    xu = longint'({32'b0, x});
    yu = longint'({32'b0, y});
    case (o)
      3'd0: begin p = xs * ys; pv = p; return pv[31:0]; end
      3'd1: begin p = xs * ys; pv = p; return pv[63:32]; end
      3'd2: begin p = xs * yu; pv = p; return pv[63:32]; end
      3'd3: begin p = xu * yu; pv = p; return pv[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        p = xs / ys; pv = p; return pv[31:0];
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        p = xu / yu; pv = p; return pv[31:0];
      end
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        p = xs % ys; pv = p; return pv[31:0];
      end
      default: begin
        if (y == 0) return x;
        p = xu % yu; pv = p; return pv[31:0];
      end
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] o, input logic [31:0] x,
                                     input logic [31:0] y);
    if (o[2] && (y == 0)) return 1;
    if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) check("spurious_done", 32'd1, 32'd0);
      else check("result", result, exp_q.pop_front());
    end
  end

  // Issue one op, wait for done, check latency (cycles counted from the start cycle)
  // and that stall stays high from the start cycle through the last busy cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] expv, input int exp_lat);
    int   lat;
    logic stall_ok;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    #1 stall_ok = (stall === 1'b1);
    @(posedge clk);
    exp_q.push_back(expv);
    #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      if (busy !== 1'b1 || stall !== 1'b1) stall_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("stall_while_busy", {31'b0, stall_ok}, 32'd1);
  endtask

  initial begin
    logic [31:0] prev;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          lat;

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy",   {31'b0, busy},  32'd0);
    check("reset_done",   {31'b0, done},  32'd0);
    check("reset_stall",  {31'b0, stall}, 32'd0);
    check("reset_result", result,         32'd0);
    rst = 1'b0;

    // Directed cases
    run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op(3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 34);
    run_op(3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34);
    run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
    run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34);
    run_op(3'd5, 32'd100,        32'd7,         32'd14,        34);
    run_op(3'd7, 32'd100,        32'd7,         32'd2,         34);
    run_op(3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    run_op(3'd6, 32'd5,          32'd0,         32'd5,         1);
    run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);

    // Randomized ops against the reference model, biased toward corner operands
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = $urandom_range(0, 50); rb = $urandom_range(1, 9); end
        3: rb = 32'($signed(-$urandom_range(1, 9)));
        default: ;
      endcase
      run_op(ro, ra, rb, ref_mdu(ro, ra, rb), exp_latency(ro, ra, rb));
    end

    // Back-to-back: start held high; new operands during busy must not disturb 3*4
    @(negedge clk);
    op = 3'd0; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk);
    exp_q.push_back(32'd12);
    #1 a = 32'd5; b = 32'd6;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    check("b2b_latency1", 32'(lat), 32'd34);
    exp_q.push_back(32'd30);
    @(posedge clk);
    #1 start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    check("b2b_latency2", 32'(lat), 32'd34);

    // Flush mid-CALC, with a start in the same cycle that must be dropped
    @(negedge clk);
    op = 3'd0; a = 32'd11; b = 32'd13; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    prev = result;
    @(negedge clk);
    flush = 1'b1; start = 1'b1; op = 3'd5; a = 32'd9; b = 32'd3;
    @(posedge clk);
    #1 flush = 1'b0; start = 1'b0;
    check("flush_busy",   {31'b0, busy}, 32'd0);
    check("flush_done",   {31'b0, done}, 32'd0);
    check("flush_result", result,        prev);
    repeat (40) @(posedge clk);
    #1 check("flush_stays_idle", {31'b0, busy}, 32'd0);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    op = 3'd5; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy",   {31'b0, busy},  32'd0);
    check("arst_done",   {31'b0, done},  32'd0);
    check("arst_stall",  {31'b0, stall}, 32'd0);
    check("arst_result", result,         32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(3'd5, 32'd9, 32'd3, 32'd3, 34);

    @(negedge clk);
    #1 check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
